// File: rtl/ship_input_ctrl.sv
// ship_input_ctrl: button synchronise/debounce front end, IDLE/PLAY/OVER game
// FSM, frame-gated 16-step spaceship angle and weapon selection.
// Optional feature macro: AUTO_REPEAT_EN (hold-to-repeat on the rotate buttons).
module ship_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 252000,
   parameter int NUM_WEAPONS     = 2,
   parameter int REPEAT_DELAY    = 7552500,
   parameter int REPEAT_PERIOD   = 2517500
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       Rotate_CW,
   input  logic       Rotate_CCW,
   input  logic       Weapon_switch,
   input  logic       Interaction,
   input  logic       frame_start,
   input  logic       game_over,
   output logic [3:0] ss_state,
   output logic [1:0] weapon,
   output logic [1:0] game_state,
   output logic       score_clear
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_PLAY = 2'b01,
      S_OVER = 2'b10
   } state_t;

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]      WPN_LAST = 2'(NUM_WEAPONS - 1);

   // Clamp a queued rotation to the +/-3 range of the 3-bit pending register.
   function automatic logic signed [2:0] sat3(input logic signed [3:0] v);
      if (v > 4'sd3)
         return 3'sd3;
      else if (v < -4'sd3)
         return -3'sd3;
      else
         return v[2:0];
   endfunction

   // Button bit order: 0 CW, 1 CCW, 2 weapon, 3 interaction (raw, active-low).
   logic [3:0]       w_btn_n;
   logic [3:0]       w_lvl;
   logic [3:0]       r_sync1, r_sync2;
   logic [3:0]       r_acc, r_acc_d, r_press;
   logic [CNT_W-1:0] r_cnt [4];

   assign w_btn_n = {Interaction, Weapon_switch, Rotate_CCW, Rotate_CW};
   assign w_lvl   = ~r_sync2;

   // Synchronise, debounce and edge-detect each button into a 1-cycle press pulse.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
         r_acc   <= '0;
         r_acc_d <= '0;
         r_press <= '0;
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_btn_n;
         r_sync2 <= r_sync1;
         r_acc_d <= r_acc;
         r_press <= r_acc & ~r_acc_d;
         for (int i = 0; i < 4; i++) begin
            if (w_lvl[i] != r_acc[i]) begin
               if (r_cnt[i] == CNT_MAX) begin
                  r_acc[i] <= w_lvl[i];
                  r_cnt[i] <= '0;
               end else begin
                  r_cnt[i] <= r_cnt[i] + 1'b1;
               end
            end else begin
               r_cnt[i] <= '0;
            end
         end
      end
   end

   state_t            r_state, w_state_n;
   logic [3:0]        r_ss, w_ss_n;
   logic [1:0]        r_weapon, w_weapon_n;
   logic signed [2:0] r_pending, w_pending_n, w_pend_sat;
   logic              r_score_clear, w_score_clear_n;
   logic              w_state_chg;
   logic [1:0]        w_rep;
   logic              w_cw, w_ccw, w_wpn, w_int;
   logic signed [3:0] w_delta;

   assign w_state_chg = (r_state != w_state_n);

`ifdef AUTO_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX) + 1;

   logic [REP_W-1:0] r_rep_cnt [2];
   logic [1:0]       r_rep_armed;
   logic [1:0]       r_rep_pulse;

   // While a rotate button stays pressed in PLAY, emit extra press pulses:
   // first after REPEAT_DELAY, then every REPEAT_PERIOD.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_rep_armed <= '0;
         r_rep_pulse <= '0;
         for (int i = 0; i < 2; i++) r_rep_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            r_rep_pulse[i] <= 1'b0;
            if (!r_acc[i] || r_state != S_PLAY || w_state_chg) begin
               r_rep_cnt[i]   <= '0;
               r_rep_armed[i] <= 1'b0;
            end else if (!r_rep_armed[i] && r_rep_cnt[i] == REP_W'(REPEAT_DELAY - 1)) begin
               r_rep_pulse[i] <= 1'b1;
               r_rep_armed[i] <= 1'b1;
               r_rep_cnt[i]   <= '0;
            end else if (r_rep_armed[i] && r_rep_cnt[i] == REP_W'(REPEAT_PERIOD - 1)) begin
               r_rep_pulse[i] <= 1'b1;
               r_rep_cnt[i]   <= '0;
            end else begin
               r_rep_cnt[i] <= r_rep_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_rep = r_rep_pulse;
`else
   logic w_unused_rep;
   assign w_unused_rep = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD), w_state_chg};
   assign w_rep        = 2'b00;
`endif

   assign w_cw  = r_press[0] | w_rep[0];
   assign w_ccw = r_press[1] | w_rep[1];
   assign w_wpn = r_press[2];
   assign w_int = r_press[3];

   // Net rotation this cycle; simultaneous CW and CCW cancel.
   always_comb begin
      w_delta = 4'sd0;
      if (w_ccw && !w_cw)
         w_delta = 4'sd1;
      else if (w_cw && !w_ccw)
         w_delta = -4'sd1;
   end

   assign w_pend_sat = sat3($signed({r_pending[2], r_pending}) + w_delta);

   // Game FSM and state registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state       <= S_IDLE;
         r_ss          <= '0;
         r_weapon      <= '0;
         r_pending     <= '0;
         r_score_clear <= 1'b0;
      end else begin
         r_state       <= w_state_n;
         r_ss          <= w_ss_n;
         r_weapon      <= w_weapon_n;
         r_pending     <= w_pending_n;
         r_score_clear <= w_score_clear_n;
      end
   end

   // Next-state logic: start/restart, queued rotation, frame-gated angle, weapon.
   always_comb begin
      w_state_n       = r_state;
      w_ss_n          = r_ss;
      w_weapon_n      = r_weapon;
      w_pending_n     = r_pending;
      w_score_clear_n = 1'b0;
      case (r_state)
         S_IDLE, S_OVER: begin
            if (w_int) begin
               w_state_n       = S_PLAY;
               w_score_clear_n = 1'b1;
               w_ss_n          = '0;
               w_weapon_n      = '0;
               w_pending_n     = '0;
            end
         end
         S_PLAY: begin
            if (game_over) begin
               w_state_n   = S_OVER;
               w_pending_n = '0;
            end else begin
               if (frame_start) begin
                  w_ss_n      = r_ss + {w_pend_sat[2], w_pend_sat};
                  w_pending_n = '0;
               end else begin
                  w_pending_n = w_pend_sat;
               end
               if (w_wpn)
                  w_weapon_n = (r_weapon == WPN_LAST) ? 2'd0 : r_weapon + 2'd1;
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   assign ss_state    = r_ss;
   assign weapon      = r_weapon;
   assign game_state  = r_state;
   assign score_clear = r_score_clear;

endmodule
